// File: rtl/noekeon_stream_if.sv
// 32-bit valid/ready streaming wrapper around a combinational Noekeon core:
// assembles key/data blocks, waits a fixed settle time, then streams the result.
module noekeon_stream_if #(
  parameter int unsigned BLOCK_SIZE    = 128,
  parameter int unsigned KEY_SIZE      = 128,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_data,
  input  logic                  in_key,
  input  logic                  in_mode,
  output logic                  core_mode,
  output logic [BLOCK_SIZE-1:0] core_plaintext,
  output logic [KEY_SIZE-1:0]   core_key,
  input  logic [BLOCK_SIZE-1:0] core_ciphertext,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SETTLE = 2'd1,
    S_OUT    = 2'd2
  } state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        key_idx_q;
  logic [IDX_W-1:0]        data_idx_q;
  logic [IDX_W-1:0]        out_idx_q;
  logic [IDX_W-1:0]        out_idx_d;
  logic [CNT_W-1:0]        settle_q;
  logic [BLOCK_SIZE-1:0]   data_q;
  logic [KEY_SIZE-1:0]     key_q;
  logic [BLOCK_SIZE-1:0]   out_q;
  logic                    mode_q;
  logic                    in_ready_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [WORD_W-1:0]       out_data_q;
  logic                    busy_q;

  // Word n occupies the n-th 32-bit slice counted from the MSB end.
  function automatic logic [WORD_W-1:0] blk_word(input logic [BLOCK_SIZE-1:0] blk,
                                                 input logic [IDX_W-1:0]      idx);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int n = 0; n < 4; n++) begin
      if (idx == IDX_W'(n)) w = blk[BLOCK_SIZE-1-WORD_W*n -: WORD_W];
    end
    return w;
  endfunction

  assign out_idx_d = out_idx_q + IDX_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_LOAD;
      key_idx_q   <= '0;
      data_idx_q  <= '0;
      out_idx_q   <= '0;
      settle_q    <= '0;
      data_q      <= '0;
      key_q       <= '0;
      out_q       <= '0;
      mode_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid && in_ready_q) begin
            if (in_key) begin
              for (int n = 0; n < 4; n++) begin
                if (key_idx_q == IDX_W'(n)) key_q[KEY_SIZE-1-WORD_W*n -: WORD_W] <= in_data;
              end
              key_idx_q <= key_idx_q + IDX_W'(1);
            end else begin
              for (int n = 0; n < 4; n++) begin
                if (data_idx_q == IDX_W'(n)) data_q[BLOCK_SIZE-1-WORD_W*n -: WORD_W] <= in_data;
              end
              if (data_idx_q == IDX_W'(0)) mode_q <= in_mode;
              if (data_idx_q == IDX_W'(3)) begin
                data_idx_q <= '0;
                settle_q   <= '0;
                state_q    <= S_SETTLE;
                in_ready_q <= 1'b0;
                busy_q     <= 1'b1;
              end else begin
                data_idx_q <= data_idx_q + IDX_W'(1);
              end
            end
          end
        end
        S_SETTLE: begin
          // Core inputs are frozen here; sample its result on the last settle cycle.
          if (settle_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            out_q       <= core_ciphertext;
            out_idx_q   <= '0;
            out_data_q  <= blk_word(core_ciphertext, IDX_W'(0));
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            settle_q <= settle_q + CNT_W'(1);
          end
        end
        S_OUT: begin
          if (out_ready && out_valid_q) begin
            if (out_idx_q == IDX_W'(3)) begin
              out_idx_q   <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= S_LOAD;
            end else begin
              out_idx_q  <= out_idx_d;
              out_data_q <= blk_word(out_q, out_idx_d);
              out_last_q <= (out_idx_d == IDX_W'(3));
            end
          end
        end
        default: begin
          state_q     <= S_LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign out_data       = out_data_q;
  assign busy           = busy_q;
  assign core_mode      = mode_q;
  assign core_plaintext = data_q;
  assign core_key       = key_q;

endmodule
